// File: rtl/boreal_ai_mailbox_pkg.sv
// Shared definitions for the AI mailbox: MMIO register map, CTRL bit layout and helpers.
package boreal_ai_mailbox_pkg;

  localparam int MB_SLOT_WORDS = 16;
  localparam int MB_SLOT_IDX_W = 4;
  localparam int MB_SEQ_W      = 16;

  localparam logic [31:0] MB_MMIO_BASE = 32'h1002_0000;

  localparam logic [11:0] MB_OFF_CTRL   = 12'h000;
  localparam logic [11:0] MB_OFF_STATUS = 12'h004;
  localparam logic [11:0] MB_OFF_SEQ0   = 12'h008;
  localparam logic [11:0] MB_OFF_SEQ1   = 12'h00C;
  localparam logic [11:0] MB_OFF_REJECT = 12'h010;
  localparam logic [11:0] MB_OFF_SLOT0  = 12'h100;
  localparam logic [11:0] MB_OFF_SLOT1  = 12'h140;

  localparam int MB_CTRL_COMMIT0    = 0;
  localparam int MB_CTRL_COMMIT1    = 1;
  localparam int MB_CTRL_CLEAR_ALL  = 2;
  localparam int MB_CTRL_CLEAR_CONS = 3;

  typedef enum logic [2:0] {
    MB_REG_NONE,
    MB_REG_CTRL,
    MB_REG_STATUS,
    MB_REG_SEQ0,
    MB_REG_SEQ1,
    MB_REG_REJECT,
    MB_REG_SLOT
  } mb_reg_e;

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] mb_sat_add(input logic [31:0] cnt, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {31'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/boreal_ai_mailbox_if.sv
// Host MMIO bus of the mailbox; the host drives requests, the mailbox answers combinationally.
interface boreal_ai_mailbox_if;
  import boreal_ai_mailbox_pkg::*;

  logic        sel;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output sel, output wr, output addr, output wdata, input rdata, input ack);
  modport slave  (input sel, input wr, input addr, input wdata, output rdata, output ack);
endinterface

// File: rtl/boreal_ai_mailbox_slot.sv
// One mailbox slot: word store, valid/consumed flags and commit sequence counter.
module boreal_mb_slot
  import boreal_ai_mailbox_pkg::*;
#(
  parameter int SLOT_WORDS = MB_SLOT_WORDS,
  parameter int SLOT_IDX_W = MB_SLOT_IDX_W,
  parameter int SEQ_W      = MB_SEQ_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [SLOT_IDX_W-1:0] widx,
  input  logic [31:0]           wdata,
  input  logic                  commit,
  input  logic                  ack,
  input  logic                  clear_all,
  input  logic                  clear_cons,
  input  logic [SLOT_IDX_W-1:0] vm_idx,
  output logic [31:0]           vm_data,
  input  logic [SLOT_IDX_W-1:0] host_idx,
  output logic [31:0]           host_data,
  output logic                  valid,
  output logic                  consumed,
  output logic [SEQ_W-1:0]      seq,
  output logic                  reject
);

  logic [31:0]      words_q [SLOT_WORDS];
  logic [31:0]      words_d [SLOT_WORDS];
  logic             valid_q, valid_d;
  logic             consumed_q, consumed_d;
  logic [SEQ_W-1:0] seq_q, seq_d;

  // A word write and a commit come from different MMIO offsets, so at most one rejects per cycle.
  always_comb begin
    words_d    = words_q;
    valid_d    = valid_q;
    consumed_d = consumed_q;
    seq_d      = seq_q;
    reject     = 1'b0;

    if (we) begin
      if (valid_q) reject = 1'b1;
      else         words_d[widx] = wdata;
    end

    if (clear_all) begin
      valid_d    = 1'b0;
      consumed_d = 1'b0;
    end else begin
      if (clear_cons) consumed_d = 1'b0;
      if (ack && valid_q) begin
        valid_d    = 1'b0;
        consumed_d = 1'b1;
      end
      // Judged against the pre-edge flag, so an ack in the same cycle cannot make room.
      if (commit) begin
        if (valid_q) begin
          reject = 1'b1;
        end else begin
          valid_d    = 1'b1;
          seq_d      = seq_q + SEQ_W'(1);
          consumed_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      consumed_q <= 1'b0;
      seq_q      <= '0;
      for (int i = 0; i < SLOT_WORDS; i++) words_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      consumed_q <= consumed_d;
      seq_q      <= seq_d;
      words_q    <= words_d;
    end
  end

  assign vm_data   = words_q[vm_idx];
  assign host_data = words_q[host_idx];
  assign valid     = valid_q;
  assign consumed  = consumed_q;
  assign seq       = seq_q;

endmodule

// File: rtl/boreal_ai_mailbox.sv
// Host-to-VM mailbox: two committed input slots, MMIO register file and reject accounting.
module boreal_ai_mailbox
  import boreal_ai_mailbox_pkg::*;
#(
  parameter int SLOT_WORDS = MB_SLOT_WORDS,
  parameter int SLOT_IDX_W = MB_SLOT_IDX_W,
  parameter int SEQ_W      = MB_SEQ_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  boreal_ai_mailbox_if.slave    mmio,
  input  logic [SLOT_IDX_W-1:0] mb_rd_idx,
  input  logic                  mb_rd_slot,
  output logic [31:0]           mb_rd_data,
  output logic                  mb_slot0_valid,
  output logic                  mb_slot1_valid,
  input  logic                  mb_slot0_ack,
  input  logic                  mb_slot1_ack,
  output logic                  irq_consumed
);

  logic [11:0]         off;
  logic [11:0]         slot_off;
  logic [SLOT_IDX_W:0] slot_word;
  logic                slot_hit;
  mb_reg_e             reg_sel;
  logic                wr_en;
  logic                ctrl_wr;
  logic [21:0]         unused_addr;

  logic [1:0]       slot_we;
  logic [1:0]       slot_commit;
  logic [1:0]       slot_ack;
  logic [1:0]       slot_valid;
  logic [1:0]       slot_consumed;
  logic [1:0]       slot_reject;
  logic [31:0]      vm_data   [2];
  logic [31:0]      host_data [2];
  logic [SEQ_W-1:0] slot_seq  [2];

  logic [31:0] reject_cnt_q, reject_cnt_d;

  assign off         = mmio.addr[11:0];
  assign slot_off    = off - MB_OFF_SLOT0;
  assign slot_word   = slot_off[SLOT_IDX_W+2:2];
  assign slot_hit    = (off >= MB_OFF_SLOT0) && (slot_off[11:SLOT_IDX_W+3] == '0);
  assign unused_addr = {mmio.addr[31:12], slot_off[1:0]};

  always_comb begin
    reg_sel = MB_REG_NONE;
    if (slot_hit) begin
      reg_sel = MB_REG_SLOT;
    end else begin
      case (off)
        MB_OFF_CTRL:   reg_sel = MB_REG_CTRL;
        MB_OFF_STATUS: reg_sel = MB_REG_STATUS;
        MB_OFF_SEQ0:   reg_sel = MB_REG_SEQ0;
        MB_OFF_SEQ1:   reg_sel = MB_REG_SEQ1;
        MB_OFF_REJECT: reg_sel = MB_REG_REJECT;
        default:       reg_sel = MB_REG_NONE;
      endcase
    end
  end

  assign wr_en   = mmio.sel & mmio.wr;
  assign ctrl_wr = wr_en && (reg_sel == MB_REG_CTRL);
  assign slot_ack = {mb_slot1_ack, mb_slot0_ack};

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign slot_we[gi]     = wr_en && (reg_sel == MB_REG_SLOT) && (slot_word[SLOT_IDX_W] == 1'(gi));
    assign slot_commit[gi] = ctrl_wr && mmio.wdata[MB_CTRL_COMMIT0 + gi];

    boreal_mb_slot #(
      .SLOT_WORDS (SLOT_WORDS),
      .SLOT_IDX_W (SLOT_IDX_W),
      .SEQ_W      (SEQ_W)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .we         (slot_we[gi]),
      .widx       (slot_word[SLOT_IDX_W-1:0]),
      .wdata      (mmio.wdata),
      .commit     (slot_commit[gi]),
      .ack        (slot_ack[gi]),
      .clear_all  (ctrl_wr && mmio.wdata[MB_CTRL_CLEAR_ALL]),
      .clear_cons (ctrl_wr && mmio.wdata[MB_CTRL_CLEAR_CONS]),
      .vm_idx     (mb_rd_idx),
      .vm_data    (vm_data[gi]),
      .host_idx   (slot_word[SLOT_IDX_W-1:0]),
      .host_data  (host_data[gi]),
      .valid      (slot_valid[gi]),
      .consumed   (slot_consumed[gi]),
      .seq        (slot_seq[gi]),
      .reject     (slot_reject[gi])
    );
  end

  // Both slots can reject in one CTRL write, hence a two-bit increment.
  always_comb begin
    reject_cnt_d = mb_sat_add(reject_cnt_q, {1'b0, slot_reject[0]} + {1'b0, slot_reject[1]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reject_cnt_q <= '0;
    else        reject_cnt_q <= reject_cnt_d;
  end

  always_comb begin
    mmio.rdata = '0;
    case (reg_sel)
      MB_REG_STATUS: mmio.rdata = {28'b0, slot_consumed[1], slot_consumed[0], slot_valid[1], slot_valid[0]};
      MB_REG_SEQ0:   mmio.rdata = 32'(slot_seq[0]);
      MB_REG_SEQ1:   mmio.rdata = 32'(slot_seq[1]);
      MB_REG_REJECT: mmio.rdata = reject_cnt_q;
      MB_REG_SLOT:   mmio.rdata = host_data[slot_word[SLOT_IDX_W]];
      default:       mmio.rdata = '0;
    endcase
  end

  assign mmio.ack       = mmio.sel;
  assign mb_rd_data     = vm_data[mb_rd_slot];
  assign mb_slot0_valid = slot_valid[0];
  assign mb_slot1_valid = slot_valid[1];
  assign irq_consumed   = |slot_consumed;

endmodule

// File: tb/tb_boreal_ai_mailbox.sv
// Directed bench for the mailbox: register reads checked against a queue of expected values.
module tb_boreal_ai_mailbox;
  import boreal_ai_mailbox_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mb_rd_idx = '0;
  logic        mb_rd_slot = 1'b0;
  logic [31:0] mb_rd_data;
  logic        mb_slot0_valid, mb_slot1_valid;
  logic        mb_slot0_ack = 1'b0;
  logic        mb_slot1_ack = 1'b0;
  logic        irq_consumed;

  boreal_ai_mailbox_if mmio ();

  boreal_ai_mailbox dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mmio           (mmio),
    .mb_rd_idx      (mb_rd_idx),
    .mb_rd_slot     (mb_rd_slot),
    .mb_rd_data     (mb_rd_data),
    .mb_slot0_valid (mb_slot0_valid),
    .mb_slot1_valid (mb_slot1_valid),
    .mb_slot0_ack   (mb_slot0_ack),
    .mb_slot1_ack   (mb_slot1_ack),
    .irq_consumed   (irq_consumed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] off;
    logic [31:0] data;
    string       tag;
  } rd_exp_t;

  rd_exp_t     sb_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] m_seq0 = '0;
  logic [15:0] m_seq1 = '0;
  logic [31:0] m_rej  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [11:0] off, input logic [31:0] data, input string tag);
    rd_exp_t e;
    e.off  = off;
    e.data = data;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    rd_exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk);
      mmio.sel  = 1'b1;
      mmio.wr   = 1'b0;
      mmio.addr = MB_MMIO_BASE | {20'b0, e.off};
      #1;
      chk(e.tag, mmio.rdata, e.data);
      mmio.sel = 1'b0;
    end
  endtask

  task automatic mmio_wr(input logic [11:0] off, input logic [31:0] data);
    @(negedge clk);
    mmio.sel   = 1'b1;
    mmio.wr    = 1'b1;
    mmio.addr  = MB_MMIO_BASE | {20'b0, off};
    mmio.wdata = data;
    @(negedge clk);
    mmio.sel = 1'b0;
    mmio.wr  = 1'b0;
  endtask

  task automatic ctrl_with_ack(input logic [31:0] data, input logic a0, input logic a1);
    @(negedge clk);
    mmio.sel     = 1'b1;
    mmio.wr      = 1'b1;
    mmio.addr    = MB_MMIO_BASE | {20'b0, MB_OFF_CTRL};
    mmio.wdata   = data;
    mb_slot0_ack = a0;
    mb_slot1_ack = a1;
    @(negedge clk);
    mmio.sel     = 1'b0;
    mmio.wr      = 1'b0;
    mb_slot0_ack = 1'b0;
    mb_slot1_ack = 1'b0;
  endtask

  task automatic pulse_ack(input logic a0, input logic a1);
    @(negedge clk);
    mb_slot0_ack = a0;
    mb_slot1_ack = a1;
    @(negedge clk);
    mb_slot0_ack = 1'b0;
    mb_slot1_ack = 1'b0;
  endtask

  // Drive a CTRL/slot write without letting a clock edge complete it.
  task automatic drive_wr(input logic [11:0] off, input logic [31:0] data);
    mmio.sel   = 1'b1;
    mmio.wr    = 1'b1;
    mmio.addr  = MB_MMIO_BASE | {20'b0, off};
    mmio.wdata = data;
  endtask

  initial begin
    mmio.sel = 1'b0; mmio.wr = 1'b0; mmio.addr = '0; mmio.wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    #1;
    chk("rst_v0", {31'b0, mb_slot0_valid}, 32'd0);
    chk("rst_v1", {31'b0, mb_slot1_valid}, 32'd0);
    chk("rst_irq", {31'b0, irq_consumed}, 32'd0);
    chk("ack_idle", {31'b0, mmio.ack}, 32'd0);
    @(negedge clk);
    mmio.sel = 1'b1; mmio.wr = 1'b0; mmio.addr = MB_MMIO_BASE | 32'h4;
    #1 chk("ack_sel", {31'b0, mmio.ack}, 32'd1);
    mmio.sel = 1'b0;
    sb_push(MB_OFF_STATUS, 32'h0, "rst_status");
    sb_push(MB_OFF_SEQ0,   32'h0, "rst_seq0");
    sb_push(MB_OFF_REJECT, 32'h0, "rst_reject");
    sb_push(12'h100,       32'h0, "rst_word0");
    sb_drain();

    // Fill and commit slot 0
    for (int i = 0; i < 16; i++) mmio_wr(12'h100 + 12'(4 * i), 32'hA000_0000 + i);
    mmio_wr(MB_OFF_CTRL, 32'h1); m_seq0++;
    #1 chk("t1_v0", {31'b0, mb_slot0_valid}, 32'd1);
    mb_rd_slot = 1'b0; mb_rd_idx = 4'd5;
    #1 chk("t1_vm_rd5", mb_rd_data, 32'hA000_0005);
    sb_push(MB_OFF_SEQ0,   32'(m_seq0), "t1_seq0");
    sb_push(MB_OFF_STATUS, 32'h1, "t1_status");
    sb_push(12'h13C,       32'hA000_000F, "t1_word15");
    sb_drain();

    // Write to a committed slot is dropped and counted; then VM consumes
    mmio_wr(12'h104, 32'hDEAD_BEEF); m_rej++;
    sb_push(12'h104,       32'hA000_0001, "t2_word1");
    sb_push(MB_OFF_REJECT, m_rej, "t2_reject");
    sb_drain();
    pulse_ack(1'b1, 1'b0);
    #1 chk("t2_v0", {31'b0, mb_slot0_valid}, 32'd0);
    chk("t2_irq", {31'b0, irq_consumed}, 32'd1);
    sb_push(MB_OFF_STATUS, 32'h4, "t2_status");
    sb_drain();

    // Commit racing an ack on a valid slot: ack wins, commit rejected
    mmio_wr(MB_OFF_CTRL, 32'h2); m_seq1++;
    #1 chk("t3_v1", {31'b0, mb_slot1_valid}, 32'd1);
    ctrl_with_ack(32'h2, 1'b0, 1'b1); m_rej++;
    #1 chk("t3_v1_acked", {31'b0, mb_slot1_valid}, 32'd0);
    sb_push(MB_OFF_SEQ1,   32'(m_seq1), "t3_seq1_hold");
    sb_push(MB_OFF_REJECT, m_rej, "t3_reject");
    sb_push(MB_OFF_STATUS, 32'hC, "t3_status_c");
    sb_drain();
    mmio_wr(MB_OFF_CTRL, 32'h2); m_seq1++;
    sb_push(MB_OFF_SEQ1,   32'(m_seq1), "t3_seq1_inc");
    sb_push(MB_OFF_STATUS, 32'h6, "t3_status_6");
    sb_drain();
    // Stray ack on an empty slot is ignored while the commit lands
    ctrl_with_ack(32'h1, 1'b1, 1'b0); m_seq0++;
    #1 chk("t3_v0_stray", {31'b0, mb_slot0_valid}, 32'd1);
    sb_push(MB_OFF_STATUS, 32'h3, "t3_status_3");
    sb_push(MB_OFF_SEQ0,   32'(m_seq0), "t3_seq0");
    sb_drain();

    // clear_all with both valid: commit bits in the same write are not counted
    mmio_wr(MB_OFF_CTRL, 32'h7);
    #1 chk("t4_v0", {31'b0, mb_slot0_valid}, 32'd0);
    chk("t4_v1", {31'b0, mb_slot1_valid}, 32'd0);
    sb_push(MB_OFF_STATUS, 32'h0, "t4_status");
    sb_push(MB_OFF_SEQ0,   32'(m_seq0), "t4_seq0");
    sb_push(MB_OFF_SEQ1,   32'(m_seq1), "t4_seq1");
    sb_push(MB_OFF_REJECT, m_rej, "t4_reject");
    sb_drain();
    mmio_wr(MB_OFF_CTRL, 32'h7);
    sb_push(MB_OFF_STATUS, 32'h0, "t4_status_b");
    sb_push(MB_OFF_SEQ0,   32'(m_seq0), "t4_seq0_b");
    sb_push(MB_OFF_REJECT, m_rej, "t4_reject_b");
    sb_drain();
    mmio_wr(MB_OFF_CTRL, 32'h1); m_seq0++;
    pulse_ack(1'b1, 1'b0);
    #1 chk("t4_irq_set", {31'b0, irq_consumed}, 32'd1);
    mmio_wr(MB_OFF_CTRL, 32'h8);
    #1 chk("t4_irq_clr", {31'b0, irq_consumed}, 32'd0);

    // Unmapped accesses, slot1 write visibility, double reject
    mmio_wr(12'h180, 32'h5555_5555);
    mmio_wr(12'h014, 32'h1);
    sb_push(12'h180,       32'h0, "un_rd180");
    sb_push(12'h014,       32'h0, "un_rd014");
    sb_push(12'h100,       32'hA000_0000, "un_word0");
    sb_push(MB_OFF_REJECT, m_rej, "un_reject");
    sb_drain();
    mmio_wr(12'h144, 32'h1111_2222);
    mb_rd_slot = 1'b1; mb_rd_idx = 4'd1;
    #1 chk("s1_vm_rd1", mb_rd_data, 32'h1111_2222);
    sb_push(12'h144, 32'h1111_2222, "s1_word1");
    sb_drain();
    mmio_wr(MB_OFF_CTRL, 32'h3); m_seq0++; m_seq1++;
    mmio_wr(MB_OFF_CTRL, 32'h3); m_rej = m_rej + 2;
    sb_push(MB_OFF_STATUS, 32'h3, "dr_status");
    sb_push(MB_OFF_SEQ0,   32'(m_seq0), "dr_seq0");
    sb_push(MB_OFF_SEQ1,   32'(m_seq1), "dr_seq1");
    sb_push(MB_OFF_REJECT, m_rej, "dr_reject");
    sb_drain();
    pulse_ack(1'b1, 1'b1);
    sb_push(MB_OFF_STATUS, 32'hC, "dr_status_c");
    sb_drain();

    // Repeated commit/ack on slot 1
    for (int k = 0; k < 8; k++) begin
      mmio_wr(MB_OFF_CTRL, 32'h2); m_seq1++;
      sb_push(MB_OFF_SEQ1, 32'(m_seq1), $sformatf("loop_seq1_%0d", k));
      sb_drain();
      pulse_ack(1'b0, 1'b1);
    end

    // SEQ1 wrap at 0xFFFF: preload the counter, evaluate the commit, put the count back
    @(negedge clk);
    force dut.g_slot[1].u_slot.seq_q = 16'hFFFF;
    drive_wr(MB_OFF_CTRL, 32'h2);
    #1 chk("seq1_wrap", {16'b0, dut.g_slot[1].u_slot.seq_d}, 32'h0);
    mmio.sel = 1'b0; mmio.wr = 1'b0;
    force dut.g_slot[1].u_slot.seq_q = m_seq1;
    #1 release dut.g_slot[1].u_slot.seq_q;
    sb_push(MB_OFF_SEQ1, 32'(m_seq1), "seq1_after");
    sb_drain();

    // REJECT_CNT saturation
    mmio_wr(MB_OFF_CTRL, 32'h3); m_seq0++; m_seq1++;
    @(negedge clk);
    force dut.reject_cnt_q = 32'hFFFF_FFFE;
    drive_wr(MB_OFF_CTRL, 32'h3);
    #1 chk("sat_fffe_p2", dut.reject_cnt_d, 32'hFFFF_FFFF);
    force dut.reject_cnt_q = 32'hFFFF_FFFF;
    drive_wr(12'h104, 32'h0BAD_0BAD);
    #1 chk("sat_ffff_p1", dut.reject_cnt_d, 32'hFFFF_FFFF);
    force dut.reject_cnt_q = 32'hFFFF_FFFC;
    drive_wr(MB_OFF_CTRL, 32'h3);
    #1 chk("sat_fffc_p2", dut.reject_cnt_d, 32'hFFFF_FFFE);
    mmio.sel = 1'b0; mmio.wr = 1'b0;
    force dut.reject_cnt_q = m_rej;
    #1 release dut.reject_cnt_q;
    sb_push(MB_OFF_REJECT, m_rej, "sat_restore");
    sb_drain();

    // Asynchronous reset in the middle of a commit cycle
    #1 chk("pre_v0", {31'b0, mb_slot0_valid}, 32'd1);
    chk("pre_v1", {31'b0, mb_slot1_valid}, 32'd1);
    mb_rd_slot = 1'b0; mb_rd_idx = 4'd5;
    #1 chk("pre_vm_rd5", mb_rd_data, 32'hA000_0005);
    @(negedge clk);
    drive_wr(MB_OFF_CTRL, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v0", {31'b0, mb_slot0_valid}, 32'd0);
    chk("arst_v1", {31'b0, mb_slot1_valid}, 32'd0);
    chk("arst_irq", {31'b0, irq_consumed}, 32'd0);
    chk("arst_vm_rd5", mb_rd_data, 32'h0);
    mmio.sel = 1'b0; mmio.wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb_push(MB_OFF_STATUS, 32'h0, "post_status");
    sb_push(MB_OFF_SEQ0,   32'h0, "post_seq0");
    sb_push(MB_OFF_SEQ1,   32'h0, "post_seq1");
    sb_push(MB_OFF_REJECT, 32'h0, "post_reject");
    sb_push(12'h100,       32'h0, "post_word0");
    sb_push(12'h13C,       32'h0, "post_word15");
    sb_push(12'h144,       32'h0, "post_s1_word1");
    sb_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/boreal_ai_mailbox.md
Name: boreal_ai_mailbox

Overview:
- Upstream feeder of the Decision VM. The AI agent host writes input words over MMIO into two 16-word slots and commits each slot.
- A committed slot raises a valid flag to the VM and is write-protected until the VM acknowledges it.
- Provides a zero-latency random-access read port for the VM.
- Keeps per-slot sequence counters and a reject counter for host-side diagnostics.

Parameters:
- SLOT_WORDS, 16, words per slot (power of two).
- SLOT_IDX_W, 4, log2(SLOT_WORDS).
- SEQ_W, 16, width of per-slot commit sequence counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sel  in  1  MMIO select.
- wr  in  1  MMIO write (1) / read (0).
- addr  in  32  MMIO byte address; only addr[11:0] decoded.
- wdata  in  32  MMIO write data.
- rdata  out  32  MMIO read data, combinational.
- ack  out  1  MMIO ack, combinational, equal to sel.
- mb_rd_idx  in  SLOT_IDX_W  VM read word index.
- mb_rd_slot  in  1  VM read slot select.
- mb_rd_data  out  32  combinational, slot[mb_rd_slot][mb_rd_idx].
- mb_slot0_valid  out  1  slot 0 committed, unconsumed.
- mb_slot1_valid  out  1  slot 1 committed, unconsumed.
- mb_slot0_ack  in  1  single-cycle pulse from VM, consumes slot 0.
- mb_slot1_ack  in  1  single-cycle pulse from VM, consumes slot 1.
- irq_consumed  out  1  level, high while any consumed-sticky bit is set.

Behaviour:
- Register map, by offset:
  - 0x00 CTRL (W): bit0 = commit slot0, bit1 = commit slot1, bit2 = clear_all, bit3 = clear consumed-sticky bits.
  - 0x04 STATUS (R): bit0 = v0, bit1 = v1, bit2 = consumed0, bit3 = consumed1.
  - 0x08 SEQ0 (R): zero-extended.
  - 0x0C SEQ1 (R): zero-extended.
  - 0x10 REJECT_CNT (R): 32-bit, saturating.
  - 0x100–0x13C: slot0 words (R/W).
  - 0x140–0x17C: slot1 words (R/W).
  - Word index = (off-0x100)>>2; slot = index[SLOT_IDX_W]. Unmapped reads return 0; unmapped writes are ignored.
- Reset: all words 0, v0 = v1 = 0, consumed bits 0, SEQ0 = SEQ1 = 0, REJECT_CNT = 0, irq_consumed = 0.
- Word write: if the target slot's valid is 0, the word is updated at the next edge. If valid is 1, the write is dropped and REJECT_CNT increments.
- Commit slot n when vn = 0: vn is set at the next edge, SEQn increments (wraps at 2^SEQ_W), consumedn is cleared.
- Commit slot n when vn = 1: no effect on vn or SEQn; REJECT_CNT increments once per rejected slot. Committing both slots in one write evaluates each independently.
- VM ack pulse on slot n with vn = 1: vn cleared and consumedn set at the next edge. An ack with vn = 0 is ignored.
- Simultaneous commit and ack on the same slot, same cycle:
  - The commit is evaluated against the pre-edge vn.
  - If vn = 1, the ack clears the slot and the commit is rejected and counted.
  - If vn = 0, the commit sets vn and the stray ack is ignored.
- clear_all: v0 = v1 = 0 and consumed bits 0 at the next edge. Words and SEQ are kept. clear_all overrides any commit or ack in the same cycle; commit bits in the same write are not counted.
- Write latency: one cycle. A word written at edge k is visible on mb_rd_data and rdata after edge k.
- Read port: purely combinational, zero cycles; valid data is returned regardless of the valid flag.
- REJECT_CNT saturates at 0xFFFF_FFFF.
- Reset asserted mid-operation: every state element returns to its reset value immediately (asynchronous).

Decomposition:
- Shared package gets MB_OFF_CTRL, MB_OFF_STATUS, MB_OFF_SEQ0, MB_OFF_SEQ1, MB_OFF_REJECT, MB_OFF_SLOT0, MB_OFF_SLOT1, the CTRL bit positions, and the MMIO base 0x1002_0000.
- One sub-module, boreal_mb_slot, instantiated twice. It holds the word array, valid flag, consumed flag and SEQ counter. It exposes write-enable, commit, ack and clear inputs plus a reject strobe; the top sums the reject strobes into REJECT_CNT.

Test Plan:
1. Write slot0 words 0..15 = 0xA000_0000+i, CTRL = 0x1 → mb_slot0_valid = 1, SEQ0 = 1; mb_rd_slot = 0, mb_rd_idx = 5 → mb_rd_data = 0xA000_0005 in the same cycle.
2. With slot0 valid, write 0xDEAD_BEEF to 0x104 → word1 unchanged (0xA000_0001), REJECT_CNT = 1. Then pulse mb_slot0_ack → v0 = 0, STATUS = 0x4, irq_consumed = 1.
3. v1 = 1; in the same cycle pulse mb_slot1_ack and write CTRL = 0x2 → v1 = 0, SEQ1 unchanged, REJECT_CNT +1. The next CTRL = 0x2 → v1 = 1, SEQ1 +1, consumed1 = 0.
4. CTRL = 0x7 with v0 = v1 = 0 → both valid remain 0, SEQ unchanged, REJECT_CNT unchanged. CTRL = 0x8 → irq_consumed = 0.
5. Commit slot1 65536 times with an ack between each → SEQ1 wraps to 0. Force REJECT_CNT near max and reject → holds 0xFFFF_FFFF.
6. Assert rst_n low mid-commit → all outputs 0 asynchronously; STATUS reads 0x0 and slot words read 0 after release.
